// File: rtl/axi_full_slave_mem.sv
// axi_full_slave_mem: AXI4 full slave backed by a word-addressed memory.
//
// Independent write and read engines, one outstanding burst per direction.
// FIXED, INCR and WRAP bursts are supported; RESERVED and WRAP with an
// unsupported length step like INCR. AxSIZE is ignored: every beat is a full
// data-width word. The burst length comes from AxLEN only; a WLAST that
// disagrees with it is reported as SLVERR, but every beat is still written.
//
// Optional feature: define AXI_FULL_SLAVE_MEM_RANGE_CHECK_EN to error bursts
// whose start word index is beyond the memory. Such writes are suppressed
// (BRESP=SLVERR) and such reads return zero data with RRESP=SLVERR.
// Without the macro, word indices simply wrap modulo C_MEM_DEPTH.
//
// Ports
//   S_AXI_ACLK, S_AXI_ARESET  clock, synchronous active-high reset
//   S_AXI_AW*                 write address channel (ID, ADDR, LEN, SIZE, BURST)
//   S_AXI_W*                  write data channel (DATA, STRB, LAST)
//   S_AXI_B*                  write response channel (ID, RESP)
//   S_AXI_AR*                 read address channel (ID, ADDR, LEN, SIZE, BURST)
//   S_AXI_R*                  read data channel (ID, DATA, RESP, LAST)
module axi_full_slave_mem #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int C_MEM_DEPTH        = 64
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                        S_AXI_AWLEN,
  input  logic [2:0]                        S_AXI_AWSIZE,
  input  logic [1:0]                        S_AXI_AWBURST,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WLAST,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_BID,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [7:0]                        S_AXI_ARLEN,
  input  logic [2:0]                        S_AXI_ARSIZE,
  input  logic [1:0]                        S_AXI_ARBURST,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RLAST,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY
);

  localparam int BYTES  = C_S_AXI_DATA_WIDTH / 8;
  localparam int BYTE_W = $clog2(BYTES);
  localparam int IDX_W  = $clog2(C_MEM_DEPTH);
  localparam int WIDX_W = C_S_AXI_ADDR_WIDTH - BYTE_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  // Next memory index for one burst step. WRAP only wraps for the legal
  // lengths 2/4/8/16 beats; anything else falls back to INCR.
  function automatic logic [IDX_W-1:0] next_index(
    input logic [IDX_W-1:0] idx,
    input logic [7:0]       len,
    input logic [1:0]       burst
  );
    logic [IDX_W-1:0] inc;
    logic [IDX_W-1:0] mask;
    logic [IDX_W+7:0] len_ext;
    inc     = idx + {{(IDX_W-1){1'b0}}, 1'b1};
    len_ext = {{IDX_W{1'b0}}, len};
    mask    = len_ext[IDX_W-1:0];
    case (burst)
      BURST_FIXED: next_index = idx;
      BURST_WRAP: begin
        if (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) begin
          next_index = (idx & ~mask) | (inc & mask);
        end else begin
          next_index = inc;
        end
      end
      default: next_index = inc;
    endcase
  endfunction

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];

  logic [WIDX_W-1:0] aw_word_s;
  logic [WIDX_W-1:0] ar_word_s;
  logic              aw_oor_s;
  logic              ar_oor_s;

  assign aw_word_s = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:BYTE_W];
  assign ar_word_s = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:BYTE_W];

`ifdef AXI_FULL_SLAVE_MEM_RANGE_CHECK_EN
  // Depth is a power of two, so "index >= depth" is "any bit above the index field set".
  assign aw_oor_s = ((aw_word_s >> IDX_W) != {WIDX_W{1'b0}});
  assign ar_oor_s = ((ar_word_s >> IDX_W) != {WIDX_W{1'b0}});
`else
  assign aw_oor_s = 1'b0;
  assign ar_oor_s = 1'b0;
`endif

  // Byte offsets, AxSIZE and the upper word-index bits carry no function here.
  logic unused_s;
  assign unused_s = ^{S_AXI_AWSIZE, S_AXI_ARSIZE, S_AXI_AWADDR[BYTE_W-1:0],
                      S_AXI_ARADDR[BYTE_W-1:0], aw_word_s, ar_word_s};

  // ---------------- write engine ----------------
  w_state_t                    w_state_r;
  logic                        awready_r;
  logic                        wready_r;
  logic                        bvalid_r;
  logic [1:0]                  bresp_r;
  logic [C_S_AXI_ID_WIDTH-1:0] bid_r;
  logic [IDX_W-1:0]            widx_r;
  logic [7:0]                  wlen_r;
  logic [1:0]                  wburst_r;
  logic [7:0]                  wcnt_r;
  logic                        wlast_err_r;
  logic                        wrange_err_r;

  logic w_hs_s;
  logic w_final_s;
  logic w_beat_err_s;
  logic mem_we_s;

  // wready_r is only ever set in W_DATA, so a handshake implies that state.
  assign w_hs_s       = S_AXI_WVALID && wready_r;
  assign w_final_s    = (wcnt_r == wlen_r);
  assign w_beat_err_s = w_final_s ? !S_AXI_WLAST : S_AXI_WLAST;
  assign mem_we_s     = w_hs_s && !wrange_err_r && !S_AXI_ARESET;

  // Write FSM: AW capture, data beats, response.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state_r    <= W_IDLE;
      awready_r    <= 1'b0;
      wready_r     <= 1'b0;
      bvalid_r     <= 1'b0;
      bresp_r      <= RESP_OKAY;
      bid_r        <= {C_S_AXI_ID_WIDTH{1'b0}};
      widx_r       <= {IDX_W{1'b0}};
      wlen_r       <= 8'd0;
      wburst_r     <= 2'b00;
      wcnt_r       <= 8'd0;
      wlast_err_r  <= 1'b0;
      wrange_err_r <= 1'b0;
    end else begin
      case (w_state_r)
        W_IDLE: begin
          if (S_AXI_AWVALID && awready_r) begin
            bid_r        <= S_AXI_AWID;
            widx_r       <= aw_word_s[IDX_W-1:0];
            wlen_r       <= S_AXI_AWLEN;
            wburst_r     <= S_AXI_AWBURST;
            wcnt_r       <= 8'd0;
            wlast_err_r  <= 1'b0;
            wrange_err_r <= aw_oor_s;
            awready_r    <= 1'b0;
            wready_r     <= 1'b1;
            w_state_r    <= W_DATA;
          end else begin
            awready_r <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs_s) begin
            widx_r <= next_index(widx_r, wlen_r, wburst_r);
            wcnt_r <= wcnt_r + 8'd1;
            if (w_final_s) begin
              wready_r  <= 1'b0;
              bvalid_r  <= 1'b1;
              bresp_r   <= (wlast_err_r || w_beat_err_s || wrange_err_r) ? RESP_SLVERR : RESP_OKAY;
              w_state_r <= W_RESP;
            end else begin
              wlast_err_r <= wlast_err_r | w_beat_err_s;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY && bvalid_r) begin
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            awready_r <= 1'b1;
            w_state_r <= W_IDLE;
          end
        end
        default: begin
          w_state_r <= W_IDLE;
          awready_r <= 1'b0;
          wready_r  <= 1'b0;
          bvalid_r  <= 1'b0;
          bresp_r   <= RESP_OKAY;
        end
      endcase
    end
  end

  // Byte-enabled memory write; the array itself is never reset.
  always_ff @(posedge S_AXI_ACLK) begin
    if (mem_we_s) begin
      for (int b = 0; b < BYTES; b++) begin
        if (S_AXI_WSTRB[b]) begin
          mem[widx_r][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
        end
      end
    end
  end

  // ---------------- read engine ----------------
  r_state_t                    r_state_r;
  logic                        arready_r;
  logic                        rvalid_r;
  logic                        rlast_r;
  logic [1:0]                  rresp_r;
  logic [C_S_AXI_ID_WIDTH-1:0] rid_r;
  logic [IDX_W-1:0]            ridx_r;
  logic [7:0]                  rlen_r;
  logic [1:0]                  rburst_r;
  logic [7:0]                  rcnt_r;
  logic                        rrange_err_r;

  // Read FSM: AR capture, then one beat per R handshake.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state_r    <= R_IDLE;
      arready_r    <= 1'b0;
      rvalid_r     <= 1'b0;
      rlast_r      <= 1'b0;
      rresp_r      <= RESP_OKAY;
      rid_r        <= {C_S_AXI_ID_WIDTH{1'b0}};
      ridx_r       <= {IDX_W{1'b0}};
      rlen_r       <= 8'd0;
      rburst_r     <= 2'b00;
      rcnt_r       <= 8'd0;
      rrange_err_r <= 1'b0;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (S_AXI_ARVALID && arready_r) begin
            rid_r        <= S_AXI_ARID;
            ridx_r       <= ar_word_s[IDX_W-1:0];
            rlen_r       <= S_AXI_ARLEN;
            rburst_r     <= S_AXI_ARBURST;
            rcnt_r       <= 8'd0;
            rrange_err_r <= ar_oor_s;
            rresp_r      <= ar_oor_s ? RESP_SLVERR : RESP_OKAY;
            rlast_r      <= (S_AXI_ARLEN == 8'd0);
            arready_r    <= 1'b0;
            rvalid_r     <= 1'b1;
            r_state_r    <= R_DATA;
          end else begin
            arready_r <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY && rvalid_r) begin
            if (rcnt_r == rlen_r) begin
              rvalid_r     <= 1'b0;
              rlast_r      <= 1'b0;
              rresp_r      <= RESP_OKAY;
              rrange_err_r <= 1'b0;
              arready_r    <= 1'b1;
              r_state_r    <= R_IDLE;
            end else begin
              ridx_r  <= next_index(ridx_r, rlen_r, rburst_r);
              rcnt_r  <= rcnt_r + 8'd1;
              rlast_r <= ((rcnt_r + 8'd1) == rlen_r);
            end
          end
        end
        default: begin
          r_state_r <= R_IDLE;
          arready_r <= 1'b0;
          rvalid_r  <= 1'b0;
          rlast_r   <= 1'b0;
          rresp_r   <= RESP_OKAY;
        end
      endcase
    end
  end

  // Read data is a combinational view of the array, so a same-cycle write
  // to the word being read shows up only after that write's clock edge.
  assign S_AXI_RDATA   = (rvalid_r && !rrange_err_r) ? mem[ridx_r] : {C_S_AXI_DATA_WIDTH{1'b0}};
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RLAST   = rlast_r;
  assign S_AXI_RRESP   = rresp_r;
  assign S_AXI_RID     = rid_r;
  assign S_AXI_ARREADY = arready_r;

  assign S_AXI_AWREADY = awready_r;
  assign S_AXI_WREADY  = wready_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_BID     = bid_r;

endmodule

// File: doc/axi_full_slave_mem.md
AXI_FULL_SLAVE_MEM -- requirements
Module: axi_full_slave_mem

Interface
REQ-001 C_S_AXI_ID_WIDTH, default 1: width of AWID, BID, ARID and RID.
REQ-002 C_S_AXI_DATA_WIDTH, default 32: data width; legal values 32, 64, 128; BYTES = C_S_AXI_DATA_WIDTH/8.
REQ-003 C_S_AXI_ADDR_WIDTH, default 12: byte address width.
REQ-004 C_MEM_DEPTH, default 64: storage depth in words; power of 2; log2(C_MEM_DEPTH)+log2(BYTES) <= C_S_AXI_ADDR_WIDTH.
REQ-005 S_AXI_ACLK  in  1  sole clock; all logic on rising edge.
REQ-006 S_AXI_ARESET  in  1  reset, synchronous, active-high.
REQ-007 AW: S_AXI_AWID in ID, S_AXI_AWADDR in ADDR, S_AXI_AWLEN in 8, S_AXI_AWSIZE in 3, S_AXI_AWBURST in 2, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1.
REQ-008 W: S_AXI_WDATA in DATA, S_AXI_WSTRB in DATA/8, S_AXI_WLAST in 1, S_AXI_WVALID in 1, S_AXI_WREADY out 1.
REQ-009 B: S_AXI_BID out ID, S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1.
REQ-010 AR: S_AXI_ARID in ID, S_AXI_ARADDR in ADDR, S_AXI_ARLEN in 8, S_AXI_ARSIZE in 3, S_AXI_ARBURST in 2, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1.
REQ-011 R: S_AXI_RID out ID, S_AXI_RDATA out DATA, S_AXI_RRESP out 2, S_AXI_RLAST out 1, S_AXI_RVALID out 1, S_AXI_RREADY in 1.
REQ-012 No LOCK/CACHE/PROT/QOS/REGION/USER ports; AxSIZE accepted and ignored (every beat full width).

Function
REQ-013 Write FSM W_IDLE/W_DATA/W_RESP; read FSM R_IDLE/R_DATA; channels fully independent, one outstanding burst each.
REQ-014 W_IDLE: AWREADY=1; on AWVALID&AWREADY latch ID, word index (AWADDR>>log2(BYTES)), LEN, BURST, clear beat counter -> W_DATA.
REQ-015 W_DATA: WREADY=1; each WVALID&WREADY writes bytes enabled by WSTRB at current index, advances index, counter+1; beat with counter==LEN -> W_RESP.
REQ-016 Burst length set solely by LEN; WLAST not asserted on final beat, or asserted on any earlier beat, sets BRESP=2'b10 (SLVERR); all beats still written.
REQ-017 W_RESP: BVALID=1, BID=latched ID, BRESP=OKAY unless REQ-016/REQ-029; on BREADY -> W_IDLE; AWREADY returns cycle after B handshake.
REQ-018 R_IDLE: ARREADY=1; on ARVALID&ARREADY latch ID, index, LEN, BURST -> R_DATA; first RVALID the next cycle.
REQ-019 R_DATA: RVALID=1, RID=latched ID, RDATA=mem[index] (combinational), RRESP=OKAY, RLAST=1 iff counter==LEN; on RVALID&RREADY advance; last handshake -> R_IDLE.
REQ-020 RDATA/RLAST/RID held stable while RVALID=1 and RREADY=0, barring a same-word write (REQ-023).
REQ-021 Address step: FIXED(00) no change; INCR(01) index+1 modulo C_MEM_DEPTH; WRAP(10) low log2(LEN+1) bits increment and wrap, upper bits held; RESERVED(11) treated as INCR.
REQ-022 WRAP with LEN not in {1,3,7,15} treated as INCR.
REQ-023 Same-cycle read of word being written returns pre-write value; new value visible from next cycle.
REQ-024 Memory index = word index modulo C_MEM_DEPTH unless REQ-029 applies.

Reset
REQ-025 While S_AXI_ARESET=1: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0; BRESP, RRESP, BID, RID, RDATA = 0.
REQ-026 First cycle after ARESET falls: W_IDLE, R_IDLE, AWREADY=ARREADY=1.
REQ-027 Reset mid-burst abandons it, no B/R completion; words already written retained.
REQ-028 Memory array not reset.

Configuration
REQ-029 AXI_FULL_SLAVE_MEM_RANGE_CHECK_EN defined: burst whose start word index >= C_MEM_DEPTH is errored; writes suppressed, BRESP=SLVERR; reads return RDATA=0, RRESP=SLVERR every beat, normal RLAST.
REQ-030 Macro undefined: no range check; index taken modulo C_MEM_DEPTH; RRESP always OKAY, BRESP SLVERR only per REQ-016.

Verification (DATA=32, ADDR=12, DEPTH=64)
REQ-031 INCR write AWADDR=0x010 LEN=3 ID=1 data 0xA0..0xA3 WSTRB=0xF, then INCR read same -> BRESP=0, BID=1; RDATA A0,A1,A2,A3, RLAST on 4th only, RID=ARID.
REQ-032 WRAP write AWADDR=0x018 LEN=3 data 1,2,3,4 -> INCR read 0x010 LEN=3 returns 3,4,1,2.
REQ-033 Word 0x11223344 at 0x020, write 0xFFFFFFFF WSTRB=0x3 -> read 0x1122FFFF.
REQ-034 FIXED read 0x010 LEN=2, RREADY pattern 1,0,0,1,1 -> 3 beats same data, outputs stable during stall, ARREADY=1 cycle after 3rd handshake.
REQ-035 Write LEN=3 with WLAST on beat 2 -> 4 beats written, BRESP=2'b10; simultaneous read of written word returns old value.
REQ-036 AWADDR=0x100 LEN=0: macro defined -> BRESP=SLVERR, word 0 unchanged; undefined -> BRESP=OKAY, word 0 updated.
